dmem_access_ctrl: RTL and testbench

//  - Initiator side of the data-memory interface: sits between the CPU execute/LDUR-STUR path and the data memory.
//  - Accepts one load/store request at a time over a valid/ready handshake.
//  - Converts the byte address to a word index and drives Addr/WriteData/MemWrite/MemRead.
//  - Samples DMout after a programmable read latency and returns the load data or a store acknowledge on a response strobe.

---
 rtl/dmem_access_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: one load/store at a time, byte address -> word index, programmable read latency.
// Optional build macro DMEM_ALIGN_CHECK_EN rejects requests whose byte address is not 8-byte aligned.
module dmem_access_ctrl #(
  parameter int REGSIZE = 64,
  parameter int DEPTH   = 64,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [REGSIZE-1:0] req_addr,
  input  logic [REGSIZE-1:0] req_wdata,
  output logic               resp_valid,
  output logic [REGSIZE-1:0] resp_rdata,
  output logic               resp_err,
  output logic [REGSIZE-1:0] Addr,
  output logic [REGSIZE-1:0] WriteData,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [REGSIZE-1:0] DMout
);

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic               is_write;
  logic [3:0]         lat_cnt;
  logic [REGSIZE-1:0] word_idx;
  logic               out_of_range;
  logic               misaligned;
  logic               illegal;
  logic               handshake;

  // Word index is zero-extended and never wrapped, so large addresses land out of range.
  assign word_idx     = {3'b000, req_addr[REGSIZE-1:3]};
  assign out_of_range = (word_idx >= REGSIZE'(DEPTH));
  assign misaligned   = (req_addr[2:0] != 3'b000);
  assign illegal      = out_of_range | (ALIGN_CHECK & misaligned);
  assign handshake    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      Addr       <= '0;
      WriteData  <= '0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      lat_cnt    <= '0;
      is_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            req_ready  <= 1'b0;
            resp_rdata <= '0;
            if (illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= ISSUE;
              is_write  <= req_write;
              Addr      <= word_idx;
              WriteData <= req_wdata;
              MemWrite  <= req_write;
              MemRead   <= ~req_write;
              resp_err  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (is_write) begin
            MemWrite   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (RD_LAT == 1) begin
            MemRead    <= 1'b0;
            resp_rdata <= DMout;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= 4'(RD_LAT - 1);
            state   <= WAIT;
          end
        end
        // The decrement that reaches zero is the last latency cycle, so DMout is sampled here.
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            lat_cnt    <= '0;
            MemRead    <= 1'b0;
            resp_rdata <= DMout;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          MemRead    <= 1'b0;
          MemWrite   <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a cycle-indexed expectation model and a latency-accurate memory.
module tb_dmem_access_ctrl;

  localparam int REGSIZE = 64;
  localparam int DEPTH   = 64;
  localparam int LAT     = 3;
  localparam int NCYC    = 1024;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [REGSIZE-1:0] req_addr;
  logic [REGSIZE-1:0] req_wdata;
  logic               resp_valid;
  logic [REGSIZE-1:0] resp_rdata;
  logic               resp_err;
  logic [REGSIZE-1:0] Addr;
  logic [REGSIZE-1:0] WriteData;
  logic               MemWrite;
  logic               MemRead;
  logic [REGSIZE-1:0] DMout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int next_free = 0;
  int rd_cycles = 0;
  bit checking = 1'b0;
  bit env_ready = 1'b0;

  logic [63:0] env_mem [DEPTH];
  logic [63:0] model_mem [DEPTH];

  bit          e_ready [NCYC];
  bit          e_mw    [NCYC];
  bit          e_mr    [NCYC];
  bit          e_rv    [NCYC];
  bit          e_err   [NCYC];
  bit          e_ac    [NCYC];
  logic [63:0] e_addr  [NCYC];
  logic [63:0] e_wd    [NCYC];
  logic [63:0] e_rdata [NCYC];

  dmem_access_ctrl #(.REGSIZE(REGSIZE), .DEPTH(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .Addr(Addr), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMout(DMout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] initWord(input int i);
    if (i == 2) return 64'h2222;
    if (i == 63) return 64'hFEED_FACE_CAFE_BEEF;
    return 64'(i);
  endfunction

  // Memory only presents valid data in the last cycle of a MemRead burst of LAT cycles.
  assign DMout = (MemRead && rd_cycles == LAT - 1 && Addr < 64'(DEPTH)) ? env_mem[Addr[5:0]]
                                                                        : 64'hBAD0_BAD0_BAD0_BAD0;

  always @(posedge clk) begin
    rd_cycles <= MemRead ? rd_cycles + 1 : 0;
    if (!env_ready) begin
      for (int i = 0; i < DEPTH; i++) env_mem[i] <= initWord(i);
      env_ready <= 1'b1;
    end else if (MemWrite === 1'b1 && Addr < 64'(DEPTH)) begin
      env_mem[Addr[5:0]] <= WriteData;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking && cyc < NCYC) begin
      checkOutput("req_ready", 64'(req_ready), 64'(e_ready[cyc]));
      checkOutput("MemWrite", 64'(MemWrite), 64'(e_mw[cyc]));
      checkOutput("MemRead", 64'(MemRead), 64'(e_mr[cyc]));
      checkOutput("resp_valid", 64'(resp_valid), 64'(e_rv[cyc]));
      checkOutput("rd_wr_exclusive", 64'(MemRead & MemWrite), 64'd0);
      if (e_ac[cyc]) checkOutput("Addr", Addr, e_addr[cyc]);
      if (e_mw[cyc]) checkOutput("WriteData", WriteData, e_wd[cyc]);
      if (e_rv[cyc]) begin
        checkOutput("resp_err", 64'(resp_err), 64'(e_err[cyc]));
        checkOutput("resp_rdata", resp_rdata, e_rdata[cyc]);
      end
    end
  end

  // Schedules the spec-level outcome of one request, then holds it until its handshake edge.
  task automatic applyStimulus(input logic w, input logic [63:0] a, input logic [63:0] d);
    int h;
    int r;
    logic [63:0] idx;
    bit bad;
    h   = (cyc + 1 > next_free) ? cyc + 1 : next_free;
    idx = a >> 3;
    bad = (idx >= 64'(DEPTH)) || (ALIGN && (a[2:0] != 3'b000));
    if (bad) begin
      r = h;
      e_err[r]   = 1'b1;
      e_rdata[r] = '0;
    end else if (w) begin
      r = h + 1;
      e_mw[h] = 1'b1;
      e_wd[h] = d;
      e_err[r]   = 1'b0;
      e_rdata[r] = '0;
      model_mem[idx[5:0]] = d;
    end else begin
      r = h + LAT;
      for (int k = h; k < r; k++) e_mr[k] = 1'b1;
      e_err[r]   = 1'b0;
      e_rdata[r] = model_mem[idx[5:0]];
    end
    if (!bad) begin
      for (int k = h; k <= r; k++) begin
        e_ac[k]   = 1'b1;
        e_addr[k] = idx;
      end
    end
    e_rv[r] = 1'b1;
    for (int k = h; k <= r; k++) e_ready[k] = 1'b0;
    next_free = r + 2;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    while (cyc + 1 < h) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic doReset(input int n);
    req_valid = 1'b0;
    rst = 1'b0;
    for (int k = cyc + 1; k < NCYC; k++) begin
      e_ready[k] = 1'b1;
      e_mw[k] = 1'b0;
      e_mr[k] = 1'b0;
      e_rv[k] = 1'b0;
      e_ac[k] = 1'b0;
    end
    repeat (n) @(negedge clk);
    rst = 1'b1;
    next_free = cyc + 1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    while (cyc < next_free) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = initWord(i);
    for (int k = 0; k < NCYC; k++) begin
      e_ready[k] = 1'b1;
      e_mw[k] = 1'b0; e_mr[k] = 1'b0; e_rv[k] = 1'b0; e_err[k] = 1'b0; e_ac[k] = 1'b0;
      e_addr[k] = '0; e_wd[k] = '0; e_rdata[k] = '0;
    end

    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_resp_err", 64'(resp_err), 64'd0);
    checkOutput("reset_resp_rdata", resp_rdata, 64'd0);
    checkOutput("reset_Addr", Addr, 64'd0);
    checkOutput("reset_WriteData", WriteData, 64'd0);
    checkOutput("reset_MemWrite", 64'(MemWrite), 64'd0);
    checkOutput("reset_MemRead", 64'(MemRead), 64'd0);
    rst = 1'b1;
    next_free = cyc + 1;
    checking = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_after_release", 64'(req_ready), 64'd1);

    $display("[TB] store 0x10 <- 0xDEAD");
    applyStimulus(1'b1, 64'h10, 64'hDEAD);
    req_valid = 1'b0;
    checkOutput("store_MemWrite", 64'(MemWrite), 64'd1);
    checkOutput("store_Addr", Addr, 64'd2);
    checkOutput("store_WriteData", WriteData, 64'hDEAD);
    @(negedge clk);
    checkOutput("store_MemWrite_off", 64'(MemWrite), 64'd0);
    checkOutput("store_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("store_resp_err", 64'(resp_err), 64'd0);
    checkOutput("store_resp_rdata", resp_rdata, 64'd0);
    drain();

    $display("[TB] load 0x28 (word 5)");
    applyStimulus(1'b0, 64'h28, 64'h0);
    req_valid = 1'b0;
    checkOutput("load_MemRead_c1", 64'(MemRead), 64'd1);
    checkOutput("load_Addr", Addr, 64'd5);
    @(negedge clk);
    checkOutput("load_MemRead_c2", 64'(MemRead), 64'd1);
    @(negedge clk);
    checkOutput("load_MemRead_c3", 64'(MemRead), 64'd1);
    checkOutput("load_no_early_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    checkOutput("load_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("load_resp_rdata", resp_rdata, 64'd5);
    checkOutput("load_MemRead_off", 64'(MemRead), 64'd0);
    drain();

    $display("[TB] out-of-range 0x200 (word 64)");
    applyStimulus(1'b0, 64'h200, 64'h0);
    req_valid = 1'b0;
    checkOutput("range_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("range_resp_err", 64'(resp_err), 64'd1);
    checkOutput("range_no_read", 64'(MemRead), 64'd0);
    checkOutput("range_no_write", 64'(MemWrite), 64'd0);
    drain();

    $display("[TB] unaligned load 0x13");
    applyStimulus(1'b0, 64'h13, 64'h0);
    req_valid = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    checkOutput("align_resp_err", 64'(resp_err), 64'd1);
    checkOutput("align_no_read", 64'(MemRead), 64'd0);
`else
    checkOutput("align_Addr", Addr, 64'd2);
    checkOutput("align_MemRead", 64'(MemRead), 64'd1);
    repeat (LAT) @(negedge clk);
    checkOutput("align_resp_rdata", resp_rdata, 64'hDEAD);
`endif
    drain();

    $display("[TB] back-to-back sequence");
    applyStimulus(1'b1, 64'h1F8, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b0, 64'h1F8, 64'h0);
    applyStimulus(1'b0, 64'h208, 64'h0);
    applyStimulus(1'b1, 64'h0, 64'h5A5A_0000_FFFF_1111);
    applyStimulus(1'b0, 64'h0, 64'h0);
    applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
    applyStimulus(1'b0, 64'h8, 64'h0);
    applyStimulus(1'b1, 64'h1F9, 64'h7777);
    applyStimulus(1'b0, 64'h1F8, 64'h0);
    drain();

    $display("[TB] reset during load wait");
    applyStimulus(1'b0, 64'h30, 64'h0);
    req_valid = 1'b0;
    @(negedge clk);
    doReset(1);
    checkOutput("abort_MemRead", 64'(MemRead), 64'd0);
    checkOutput("abort_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    checkOutput("abort_no_resp", 64'(resp_valid), 64'd0);
    applyStimulus(1'b0, 64'h28, 64'h0);
    req_valid = 1'b0;
    repeat (LAT) @(negedge clk);
    checkOutput("after_abort_rdata", resp_rdata, 64'd5);
    drain();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
